decode_byte_queue: RTL
======================

// Module: decode_byte_queue
// PURPOSE
//  Instruction-byte queue between fetch and the opcode decoder.
//  - Accepts 8-byte aligned fetch chunks and buffers them in a circular byte queue.
//  - Presents a WINDOW-byte window at the current decode position, ordered the way
//    the opcode/prefix/ModRM decode functions expect.
//  - Retires the bytes the decoder consumes and tracks the PC of the window head.
//  - Handles redirects: flush plus new PC, with the unaligned start bytes dropped.
// PARAMETERS
//  DEPTH     32       queue capacity in bytes; power of 2, >= WINDOW+8
//  WINDOW    16       bytes presented to decode; >= 15, the max x86-64 instruction length
//  RESET_PC  64'h0    head_pc value after reset
// PORTS
//  clk           in   1             clock, rising edge
//  reset_n       in   1             asynchronous reset, active low
//  in_valid      in   1             fetch chunk valid
//  in_ready      out  1             queue can accept a chunk
//  in_data       in   64            chunk; byte k at bits [8k+:8] = address chunk_base+k
//  flush         in   1             redirect: discard all bytes
//  flush_pc      in   64            new fetch PC (may be unaligned)
//  out_bytes     out  [0:WINDOW*8-1] byte i at bits [i*8 +: 8], i=0 is head
//  out_count     out  $clog2(WINDOW+1) valid bytes in window, min(count, WINDOW)
//  head_pc       out  64            address of out_bytes byte 0
//  consume_valid in   1             decoder retires consume_len bytes this cycle
//  consume_len   in   4             1..15 bytes retired
// BEHAVIOUR
//  State
//  - rd_ptr, wr_ptr: $clog2(DEPTH) bits, wrap modulo DEPTH.
//  - count: $clog2(DEPTH+1) bits.
//  - skip: 3 bits. pc_q: 64 bits.
//  Reset (async, reset_n=0)
//  - count=0, both pointers=0, skip=0, pc_q=RESET_PC.
//  - Outputs: out_count=0, out_bytes=0, head_pc=RESET_PC, in_ready=1.
//  Outputs
//  - in_ready = (DEPTH-count) >= 8, combinational from registered count. There is no
//    bypass, so a same-cycle consume does not free space early.
//  - Window is combinational from registered state.
//  - Bytes at window index >= out_count are driven 0.
//  - A chunk accepted in cycle N is visible at the window in N+1.
//  - A consume in cycle N advances the window and head_pc in N+1.
//  Push (in_valid & in_ready & ~flush)
//  - Write bytes skip..7 at wr_ptr onward.
//  - wr_ptr += 8-skip, then skip<=0.
//  Consume (consume_valid & ~flush)
//  - n = min(consume_len, out_count).
//  - rd_ptr += n, pc_q += n (64-bit, wraps).
//  - consume_len > out_count is a decoder bug: simulation assertion fires, consume
//    is clamped to out_count.
//  - consume_len=0 with consume_valid is a no-op.
//  Simultaneous push and consume
//  - count_next = count + pushed - n.
//  - Both act in the same cycle; pointers are independent.
//  Flush
//  - Highest priority. count<=0, rd_ptr<=wr_ptr<=0.
//  - pc_q<=flush_pc, skip<=flush_pc[2:0].
//  - Same-cycle in_valid data and consume are ignored (in_ready may read 1; the
//    chunk is dropped).
//  - Fetch must deliver the chunk at {flush_pc[63:3],3'b0} next.
//  Wrap-around
//  - Window read index = (rd_ptr+i) mod DEPTH.
//  - Writes straddling the end of the array wrap the same way.
//  Full/empty
//  - Full (count > DEPTH-8): in_ready=0.
//  - Empty: out_count=0. consume_valid is illegal and is clamped to 0.
//  Reset mid-operation
//  - Immediate async clear to the reset state; in-flight handshakes are lost.
// STRUCTURE
//  - DecoderTypes package gains:
//      localparam FETCH_BYTES=8
//      typedef logic[0:WINDOW*8-1] inst_window_t
//  - Sub-module decode_window_mux: combinational rotate of storage by rd_ptr plus
//    masking beyond out_count.
//  - The top level holds the storage array, pointers, count, skip, pc_q and the
//    handshake logic.
// TESTING
//  1. Hold reset_n=0, then release.
//     -> out_count=0, in_ready=1, head_pc=RESET_PC. Nothing changes with no stimulus.
//  2. Push in_data=64'h0706050403020100.
//     -> next cycle out_count=8, byte0=8'h00, byte7=8'h07, bytes 8..15=0.
//  3. Push 4 chunks with no consume (DEPTH=32).
//     -> in_ready=0 at count 32, out_count=16.
//     -> Consume 8: count 24, in_ready=1 next cycle.
//  4. flush_pc=64'h1003, then push 64'h0706050403020100.
//     -> out_count=5, byte0=8'h03, head_pc=64'h1003.
//  5. count=8, head_pc=P; push and consume_len=3 in the same cycle.
//     -> count=13, head_pc=P+3, byte0 = old byte3.
//  6. Stream 200 random chunks with random legal consumes, plus one flush and one
//     reset_n pulse mid-stream.
//     -> Window matches the reference byte model across pointer wrap.
//     -> The state after the flush or reset pulse is as in tests 1 and 4.

Source files
------------

// File: rtl/decode_byte_queue_pkg.sv
// Shared constants and types for the instruction-byte queue feeding the decoder.
package decode_byte_queue_pkg;
   localparam int FETCH_BYTES = 8;
   localparam int DEF_WINDOW  = 16;

   typedef logic [0:DEF_WINDOW*8-1] inst_window_t;
endpackage

// File: rtl/decode_window_mux.sv
// Rotates the circular byte store so the head byte lands at window index 0,
// zeroing every byte at or beyond the valid count.
module decode_window_mux #(
   parameter int DEPTH  = 32,
   parameter int WINDOW = 16,
   parameter int PTR_W  = $clog2(DEPTH),
   parameter int OCNT_W = $clog2(WINDOW+1)
) (
   input  logic [DEPTH-1:0][7:0]  mem,
   input  logic [PTR_W-1:0]       rd_ptr,
   input  logic [OCNT_W-1:0]      out_count,
   output logic [0:WINDOW*8-1]    window
);

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      window = '0;
      for (int i = 0; i < WINDOW; i++) begin
         if (i < int'(out_count)) begin
            window[i*8 +: 8] = mem[rd_ptr + PTR_W'(i)];
         end
      end
   end

endmodule

// File: rtl/decode_byte_queue.sv
// Circular instruction-byte queue: buffers aligned fetch chunks, presents a decode
// window at the head, retires consumed bytes and tracks the head PC across redirects.
module decode_byte_queue
   import decode_byte_queue_pkg::*;
#(
   parameter int          DEPTH    = 32,
   parameter int          WINDOW   = 16,
   parameter logic [63:0] RESET_PC = 64'h0
) (
   input  logic                          clk,
   input  logic                          reset_n,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [63:0]                   in_data,
   input  logic                          flush,
   input  logic [63:0]                   flush_pc,
   output logic [0:WINDOW*8-1]           out_bytes,
   output logic [$clog2(WINDOW+1)-1:0]   out_count,
   output logic [63:0]                   head_pc,
   input  logic                          consume_valid,
   input  logic [3:0]                    consume_len
);

   localparam int PTR_W  = $clog2(DEPTH);
   localparam int CNT_W  = $clog2(DEPTH+1);
   localparam int OCNT_W = $clog2(WINDOW+1);

   logic [DEPTH-1:0][7:0] mem_q, mem_d;
   logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0]      count_q, count_d;
   logic [2:0]            skip_q, skip_d;
   logic [63:0]           pc_q, pc_d;

   logic                  push;
   logic [3:0]            push_n;
   logic [OCNT_W-1:0]     consume_n;

   // Space is judged on registered count only; a same-cycle consume frees nothing.
   assign in_ready  = count_q <= CNT_W'(DEPTH - FETCH_BYTES);
   assign out_count = (count_q >= CNT_W'(WINDOW)) ? OCNT_W'(WINDOW) : OCNT_W'(count_q);
   assign head_pc   = pc_q;
   assign push      = in_valid & in_ready & ~flush;
   assign push_n    = 4'(FETCH_BYTES) - {1'b0, skip_q};

   always_comb begin
      consume_n = '0;
      if (consume_valid && !flush) begin
         consume_n = (OCNT_W'(consume_len) > out_count) ? out_count : OCNT_W'(consume_len);
      end
   end

   always_comb begin
      mem_d    = mem_q;
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      skip_d   = skip_q;
      pc_d     = pc_q;
      if (flush) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
         pc_d     = flush_pc;
         skip_d   = flush_pc[2:0];
      end else begin
         if (push) begin
            // Bytes below skip precede the redirect target and are dropped.
            for (int k = 0; k < FETCH_BYTES; k++) begin
               if (k >= int'(skip_q)) begin
                  mem_d[wr_ptr_q + PTR_W'(k) - PTR_W'(skip_q)] = in_data[k*8 +: 8];
               end
            end
            wr_ptr_d = wr_ptr_q + PTR_W'(push_n);
            skip_d   = '0;
         end
         rd_ptr_d = rd_ptr_q + PTR_W'(consume_n);
         pc_d     = pc_q + 64'(consume_n);
         count_d  = count_q + (push ? CNT_W'(push_n) : CNT_W'(0)) - CNT_W'(consume_n);
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update together.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
         skip_q   <= '0;
         pc_q     <= RESET_PC;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
         skip_q   <= skip_d;
         pc_q     <= pc_d;
      end
   end

   // NOTE: the byte store has no reset; stale bytes are never visible because the
   // window masks everything beyond count.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   decode_window_mux #(
      .DEPTH  (DEPTH),
      .WINDOW (WINDOW),
      .PTR_W  (PTR_W),
      .OCNT_W (OCNT_W)
   ) u_window_mux (
      .mem       (mem_q),
      .rd_ptr    (rd_ptr_q),
      .out_count (out_count),
      .window    (out_bytes)
   );

   // Over-consuming is a decoder bug; the hardware clamps it regardless.
   assert property (@(posedge clk) disable iff (!reset_n)
      (consume_valid && !flush) |-> ({1'b0, consume_len} <= 5'(out_count)));

endmodule
